// File: rtl/isa_shared.sv
// Shared ISA encodings used by the load/store path: sign-extension opcodes,
// LSU funct3 values and the alignment-stage state encoding.
package isa_shared;

  // Sign-extension opcodes consumed by the sign-extension stage (sx_op).
  localparam logic [2:0] SX_3100  = 3'd0;
  localparam logic [2:0] SX_0700  = 3'd1;
  localparam logic [2:0] SX_1500  = 3'd2;
  localparam logic [2:0] SXU_0700 = 3'd5;
  localparam logic [2:0] SXU_1500 = 3'd6;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } lsu_state_t;

endpackage

// File: rtl/lsu_mem_align_if.sv
// Bundles the execute-side request, data-memory port and response channel
// of the load/store alignment stage.
interface lsu_mem_align_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  // Handshakes: a transfer happens on a rising clk edge where valid (or
  // mem_req) and ready (or mem_gnt) are both high; once raised, valid and its
  // payload stay stable until that edge. mem_rvalid is a one-cycle strobe.
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_is_store;
  logic [2:0]            req_funct3;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;

  logic                  mem_req;
  logic                  mem_gnt;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_we;
  logic [3:0]            mem_wstrb;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_rvalid;
  logic [DATA_WIDTH-1:0] mem_rdata;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic [2:0]            rsp_sx_op;
  logic                  rsp_err;

  modport slave (
    input  req_valid, req_is_store, req_funct3, req_addr, req_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata, rsp_ready,
    output req_ready, mem_req, mem_addr, mem_we, mem_wstrb, mem_wdata,
    output rsp_valid, rsp_data, rsp_sx_op, rsp_err
  );

  modport master (
    output req_valid, req_is_store, req_funct3, req_addr, req_wdata,
    output mem_gnt, mem_rvalid, mem_rdata, rsp_ready,
    input  req_ready, mem_req, mem_addr, mem_we, mem_wstrb, mem_wdata,
    input  rsp_valid, rsp_data, rsp_sx_op, rsp_err
  );
endinterface

// File: rtl/lsu_lane_align.sv
// Byte-lane steering for one access: store strobes and lane replication,
// load shift/mask, extension opcode, and illegal/misaligned detection.
module lsu_lane_align
  import isa_shared::*;
(
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  input  logic        is_store,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_align,
  output logic [2:0]  sx_op,
  output logic        err
);
  logic [31:0] shifted;
  logic        illegal;
  logic        misalign;

  always_comb begin
    shifted     = rdata >> {offset, 3'b000};
    wstrb       = 4'b0000;
    wdata_rep   = wdata;
    rdata_align = '0;
    sx_op       = SX_3100;
    illegal     = 1'b0;
    misalign    = 1'b0;
    case (funct3)
      F3_B, F3_BU: begin
        wstrb       = 4'b0001 << offset;
        wdata_rep   = {4{wdata[7:0]}};
        rdata_align = {24'h0, shifted[7:0]};
        sx_op       = (funct3 == F3_BU) ? SXU_0700 : SX_0700;
        illegal     = is_store && (funct3 == F3_BU);
      end
      F3_H, F3_HU: begin
        wstrb       = 4'b0011 << offset;
        wdata_rep   = {2{wdata[15:0]}};
        rdata_align = {16'h0, shifted[15:0]};
        sx_op       = (funct3 == F3_HU) ? SXU_1500 : SX_1500;
        illegal     = is_store && (funct3 == F3_HU);
        misalign    = offset[0];
      end
      F3_W: begin
        wstrb       = 4'b1111;
        rdata_align = rdata;
        misalign    = (offset != 2'b00);
      end
      default: illegal = 1'b1;
    endcase
    err = illegal | misalign;
  end
endmodule

// File: rtl/lsu_mem_align.sv
// Load/store alignment stage: one access at a time, word-aligned memory
// request with strobes, right-justified load data plus extension opcode.
module lsu_mem_align
  import isa_shared::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  lsu_mem_align_if.slave      bus,
  output lsu_state_t          dbg_state
);
  if (DATA_WIDTH != 32) begin : g_bad_width
    $error("lsu_mem_align supports DATA_WIDTH=32 only");
  end

  lsu_state_t            state, state_nxt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [2:0]            funct3_q;
  logic                  is_store_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rsp_data_q;
  logic [2:0]            rsp_sx_op_q;
  logic                  rsp_err_q;

  logic                  accept;
  logic                  capture;
  logic                  in_idle;
  logic                  in_req;
  logic [1:0]            la_off;
  logic [2:0]            la_f3;
  logic                  la_store;
  logic [3:0]            la_wstrb;
  logic [31:0]           la_wdata;
  logic [31:0]           la_rdata;
  logic [2:0]            la_sx_op;
  logic                  la_err;

  assign in_idle = (state == IDLE);
  assign in_req  = (state == REQ);

  // In IDLE the lane logic decodes the incoming request so errors are known
  // at accept time; afterwards it works from the latched copy.
  assign la_off   = in_idle ? bus.req_addr[1:0]  : addr_q[1:0];
  assign la_f3    = in_idle ? bus.req_funct3     : funct3_q;
  assign la_store = in_idle ? bus.req_is_store   : is_store_q;

  lsu_lane_align u_lane (
    .offset      (la_off),
    .funct3      (la_f3),
    .is_store    (la_store),
    .wdata       (wdata_q),
    .rdata       (bus.mem_rdata),
    .wstrb       (la_wstrb),
    .wdata_rep   (la_wdata),
    .rdata_align (la_rdata),
    .sx_op       (la_sx_op),
    .err         (la_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    accept        = 1'b0;
    capture       = 1'b0;
    bus.req_ready = in_idle;
    bus.mem_req   = in_req;
    bus.mem_addr  = in_req ? {addr_q[ADDR_WIDTH-1:2], 2'b00} : '0;
    bus.mem_we    = in_req && is_store_q;
    bus.mem_wstrb = (in_req && is_store_q) ? la_wstrb : 4'b0000;
    bus.mem_wdata = (in_req && is_store_q) ? la_wdata : '0;
    bus.rsp_valid = (state == RESP);
    bus.rsp_data  = rsp_data_q;
    bus.rsp_sx_op = rsp_sx_op_q;
    bus.rsp_err   = rsp_err_q;
    case (state)
      IDLE: if (bus.req_valid) begin
        accept    = 1'b1;
        state_nxt = la_err ? RESP : REQ;
      end
      REQ:  if (bus.mem_gnt)    state_nxt = WAIT;
      WAIT: if (bus.mem_rvalid) begin
        capture   = 1'b1;
        state_nxt = RESP;
      end
      RESP: if (bus.rsp_ready)  state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q      <= '0;
      funct3_q    <= 3'b000;
      is_store_q  <= 1'b0;
      wdata_q     <= '0;
      rsp_data_q  <= '0;
      rsp_sx_op_q <= SX_3100;
      rsp_err_q   <= 1'b0;
    end else begin
      if (accept) begin
        addr_q     <= bus.req_addr;
        funct3_q   <= bus.req_funct3;
        is_store_q <= bus.req_is_store;
        wdata_q    <= bus.req_wdata;
        rsp_err_q  <= la_err;
        if (la_err) begin
          rsp_data_q  <= '0;
          rsp_sx_op_q <= SX_3100;
        end
      end
      if (capture) begin
        rsp_err_q <= 1'b0;
        if (is_store_q) begin
          rsp_data_q  <= '0;
          rsp_sx_op_q <= SX_3100;
        end else begin
          rsp_data_q  <= la_rdata;
          rsp_sx_op_q <= la_sx_op;
        end
      end
    end
  end

  assign dbg_state = state;
endmodule
